// File: rtl/mux7_rr_arbiter.sv
// Round-robin arbiter that time-shares one 7-to-1 mux among seven requesters.
// A hold timer bounds each grant, and every output is driven straight from a flop.
module mux7_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] req,
    output logic [6:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       preempt_q, preempt_d;

    logic [3:0] idleWin;
    logic [3:0] grantWin;
    logic [2:0] nextPtr;

    function automatic logic [2:0] nextIdx(input logic [2:0] i);
        return (i == 3'd6) ? 3'd0 : i + 3'd1;
    endfunction

    // Returns {found, index} of the first asserted request at or after start, modulo 7.
    function automatic logic [3:0] search(input logic [6:0] r, input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        idx   = start;
        win   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = nextIdx(idx);
        end
        return {found, win};
    endfunction

    assign nextPtr  = nextIdx(owner_q);
    assign idleWin  = search(req, ptr_q);
    assign grantWin = search(req, nextPtr);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        grant_d   = 7'b0;
        sel_d     = 3'b111;
        busy_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (idleWin[3]) begin
                    state_d = GRANT;
                    owner_d = idleWin[2:0];
                    cnt_d   = 8'd0;
                end
            end
            GRANT: begin
                if (req[owner_q] && (cnt_q < HOLD_LAST)) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    // Searching from owner+1 leaves the current owner as the last candidate.
                    ptr_d     = nextPtr;
                    preempt_d = req[owner_q];
                    cnt_d     = 8'd0;
                    if (grantWin[3]) begin
                        owner_d = grantWin[2:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GRANT) begin
            grant_d = 7'b1 << owner_d;
            sel_d   = owner_d;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 3'd0;
            ptr_q     <= 3'd0;
            cnt_q     <= 8'd0;
            grant_q   <= 7'b0;
            sel_q     <= 3'b111;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux7_rr_arbiter.sv
// Scoreboard bench for mux7_rr_arbiter: two instances (MAX_HOLD 8 and 1) share
// stimulus; a behavioural model queues expected outputs for each edge.
module tb_mux7_rr_arbiter;

    logic       clock;
    logic       reset;
    logic [6:0] req;
    logic [6:0] grant8, grant1;
    logic [2:0] sel8, sel1;
    logic       busy8, busy1, preempt8, preempt1;

    typedef struct {
        int owner;
        int ptr;
        int held;
        bit preempt;
    } mdl_t;

    typedef struct {
        logic [6:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic       preempt;
    } exp_t;

    mdl_t m8, m1;
    exp_t q8[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;

    mux7_rr_arbiter #(.MAX_HOLD(8)) dut8 (
        .clock(clock), .reset(reset), .req(req),
        .grant(grant8), .sel(sel8), .busy(busy8), .preempt(preempt8)
    );

    mux7_rr_arbiter #(.MAX_HOLD(1)) dut1 (
        .clock(clock), .reset(reset), .req(req),
        .grant(grant1), .sel(sel1), .busy(busy1), .preempt(preempt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model state: owner = -1 means idle; held = cycles owned so far.
    function automatic mdl_t modelReset();
        mdl_t m;
        m.owner   = -1;
        m.ptr     = 0;
        m.held    = 0;
        m.preempt = 1'b0;
        return m;
    endfunction

    function automatic mdl_t modelStep(mdl_t m, logic [6:0] r, int maxHold);
        mdl_t n;
        int   start;
        bit   decide;
        n         = m;
        n.preempt = 1'b0;
        decide    = 1'b0;
        start     = m.ptr;
        if (m.owner < 0) begin
            decide = (r != 7'b0);
        end else if (r[m.owner] && m.held < maxHold) begin
            n.held = m.held + 1;
        end else begin
            n.preempt = r[m.owner];
            n.ptr     = (m.owner + 1) % 7;
            start     = n.ptr;
            n.owner   = -1;
            n.held    = 0;
            decide    = 1'b1;
        end
        if (decide) begin
            for (int k = 0; k < 7; k++) begin
                if (n.owner < 0 && r[(start + k) % 7]) begin
                    n.owner = (start + k) % 7;
                    n.held  = 1;
                end
            end
        end
        return n;
    endfunction

    function automatic exp_t expOf(mdl_t m);
        exp_t e;
        e.grant   = (m.owner < 0) ? 7'b0 : 7'(1 << m.owner);
        e.sel     = (m.owner < 0) ? 3'b111 : 3'(m.owner);
        e.busy    = (m.owner >= 0);
        e.preempt = m.preempt;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compareQueues(input string tag);
        exp_t e;
        checkOutput({tag, ".q8"}, 32'(q8.size()), 32'd1);
        checkOutput({tag, ".q1"}, 32'(q1.size()), 32'd1);
        if (q8.size() > 0) begin
            e = q8.pop_front();
            checkOutput({tag, ".grant8"}, 32'(grant8), 32'(e.grant));
            checkOutput({tag, ".sel8"}, 32'(sel8), 32'(e.sel));
            checkOutput({tag, ".busy8"}, 32'(busy8), 32'(e.busy));
            checkOutput({tag, ".preempt8"}, 32'(preempt8), 32'(e.preempt));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput({tag, ".grant1"}, 32'(grant1), 32'(e.grant));
            checkOutput({tag, ".sel1"}, 32'(sel1), 32'(e.sel));
            checkOutput({tag, ".busy1"}, 32'(busy1), 32'(e.busy));
            checkOutput({tag, ".preempt1"}, 32'(preempt1), 32'(e.preempt));
        end
    endtask

    // Drive req at the falling edge, queue the model's prediction, compare just after the rising edge.
    task automatic applyStimulus(input logic [6:0] r, input string tag);
        @(negedge clock);
        req = r;
        m8 = modelStep(m8, r, 8);
        m1 = modelStep(m1, r, 1);
        q8.push_back(expOf(m8));
        q1.push_back(expOf(m1));
        @(posedge clock);
        #1;
        compareQueues(tag);
    endtask

    // Asserts reset wherever the clock happens to be and checks the clear happens without an edge.
    task automatic resetDut(input string tag);
        reset = 1'b1;
        req   = 7'b0;
        #1;
        checkOutput({tag, ".grant8"}, 32'(grant8), 32'h0);
        checkOutput({tag, ".sel8"}, 32'(sel8), 32'h7);
        checkOutput({tag, ".busy8"}, 32'(busy8), 32'h0);
        checkOutput({tag, ".preempt8"}, 32'(preempt8), 32'h0);
        checkOutput({tag, ".grant1"}, 32'(grant1), 32'h0);
        checkOutput({tag, ".sel1"}, 32'(sel1), 32'h7);
        m8 = modelReset();
        m1 = modelReset();
        q8.delete();
        q1.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int         pulses;
        logic [6:0] r;
        reset = 1'b1;
        req   = 7'b0;
        #2;
        resetDut("por");

        for (int i = 0; i < 5; i++) applyStimulus(7'b0000000, "idle");

        applyStimulus(7'b0001000, "single");
        checkOutput("single.grant", 32'(grant8), 32'h08);
        checkOutput("single.sel", 32'(sel8), 32'h3);
        applyStimulus(7'b0000000, "single.drop");
        checkOutput("single.dropsel", 32'(sel8), 32'h7);

        resetDut("rst.all");
        for (int i = 0; i < 60; i++) applyStimulus(7'b1111111, "allreq");

        resetDut("rst.handoff");
        applyStimulus(7'b0000100, "handoff.pre");
        applyStimulus(7'b0100101, "handoff.hold");
        applyStimulus(7'b0100101, "handoff.hold");
        applyStimulus(7'b0100001, "handoff.move");
        checkOutput("handoff.grant", 32'(grant8), 32'h20);

        resetDut("rst.sole");
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(7'b0010000, "sole");
            if (preempt8) pulses++;
        end
        checkOutput("sole.pulses", 32'(pulses), 32'd2);

        resetDut("rst.async");
        applyStimulus(7'b1000000, "async.grant");
        applyStimulus(7'b1000000, "async.grant");
        #2;
        resetDut("async.midgrant");
        applyStimulus(7'b1000001, "async.after");
        checkOutput("async.ptr0", 32'(grant8), 32'h01);

        r = 7'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) r = 7'($urandom);
            applyStimulus(r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
